// File: rtl/convergecast_pkg.sv
// Sizing helpers for the convergecast min-reduction tree.
// Pure elaboration-time functions, no logic and no latency.
// No flow control of its own.
package convergecast_pkg;

    // Integer ceiling division for level sizing.
    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Number of entries present at a given level; level 0 is the leaves.
    function automatic int level_count(input int nodes, input int fanin, input int level);
        int n;
        n = nodes;
        for (int k = 0; k < level; k++) begin
            n = ceil_div(n, fanin);
        end
        return n;
    endfunction

    // Number of register stages. A single leaf still gets one stage.
    function automatic int tree_depth(input int nodes, input int fanin);
        int n;
        int d;
        n = nodes;
        d = 0;
        if (nodes <= 1) begin
            return 1;
        end
        // Fan-in is at least 2, so 64 halvings covers any int-sized tree.
        for (int k = 0; k < 64; k++) begin
            if (n > 1) begin
                n = ceil_div(n, fanin);
                d = d + 1;
            end
        end
        return d;
    endfunction

    // Width of the absolute leaf index; never narrower than one bit.
    function automatic int index_width(input int nodes);
        return (nodes <= 1) ? 1 : $clog2(nodes);
    endfunction

endpackage

// File: rtl/convergecast_level.sv
// One tree level: reduces IN_COUNT entries to ceil(IN_COUNT/MAX_FANIN) minima.
// Latency one cycle; strobe is delayed alongside the data.
// No backpressure: every cycle advances regardless of strobe.
module convergecast_level
    import convergecast_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int INDEX_WIDTH = 7,
    parameter int MAX_FANIN   = 3,
    parameter int IN_COUNT    = 100,
    localparam int OUT_COUNT  = ceil_div(IN_COUNT, MAX_FANIN),
    localparam int ENTRY_W    = 1 + DATA_WIDTH + INDEX_WIDTH
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               in_strobe,
    input  logic [IN_COUNT-1:0][ENTRY_W-1:0]   in_entries,
    output logic                               out_strobe,
    output logic [OUT_COUNT-1:0][ENTRY_W-1:0]  out_entries
);

    typedef struct packed {
        logic                   valid;
        logic [DATA_WIDTH-1:0]  data;
        logic [INDEX_WIDTH-1:0] index;
    } entry_t;

    logic [OUT_COUNT-1:0][ENTRY_W-1:0] next_entries;

    for (genvar j = 0; j < OUT_COUNT; j++) begin : g_cell
        // Contiguous group; the last one may be short (down to a single entry).
        localparam int BASE = j * MAX_FANIN;
        localparam int GSZ  = ((IN_COUNT - BASE) < MAX_FANIN) ? (IN_COUNT - BASE) : MAX_FANIN;

        entry_t best;
        entry_t cand;

        // Minimum over valid entries; equal data resolves to the lower leaf index.
        // An all-invalid group yields an all-zero entry, never stale data.
        always_comb begin
            best = '0;
            cand = '0;
            for (int i = 0; i < GSZ; i++) begin
                cand = in_entries[BASE + i];
                if (cand.valid &&
                    (!best.valid ||
                     (cand.data < best.data) ||
                     ((cand.data == best.data) && (cand.index < best.index)))) begin
                    best = cand;
                end
            end
        end

        assign next_entries[j] = best;
    end

    // Stage register; reset discards anything in flight, strobe included.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_entries <= '0;
            out_strobe  <= 1'b0;
        end else begin
            out_entries <= next_entries;
            out_strobe  <= in_strobe;
        end
    end

endmodule

// File: rtl/convergecast_tree.sv
// Pipelined min-reduction over NODES (valid, data) responses, returning min data and its leaf index.
// Latency DEPTH cycles (one register per tree level), one round per cycle.
// No backpressure; results are only meaningful while output_strobe is high.
module convergecast_tree
    import convergecast_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int MAX_FANIN   = 3,
    parameter int NODES       = 100,
    localparam int INDEX_WIDTH = index_width(NODES)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   input_strobe,
    input  logic [NODES-1:0]       input_valids,
    input  logic [DATA_WIDTH-1:0]  inputs [0:NODES-1],
    output logic                   output_strobe,
    output logic                   output_valid,
    output logic [DATA_WIDTH-1:0]  output_data,
    output logic [INDEX_WIDTH-1:0] output_index
);

    localparam int DEPTH   = tree_depth(NODES, MAX_FANIN);
    localparam int ENTRY_W = 1 + DATA_WIDTH + INDEX_WIDTH;

    typedef struct packed {
        logic                   valid;
        logic [DATA_WIDTH-1:0]  data;
        logic [INDEX_WIDTH-1:0] index;
    } entry_t;

    logic [NODES-1:0][ENTRY_W-1:0] leaves;

    // Leaves carry their absolute index so no level has to translate local positions.
    for (genvar i = 0; i < NODES; i++) begin : g_leaf
        assign leaves[i] = {input_valids[i], inputs[i], INDEX_WIDTH'(i)};
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_lvl
        localparam int IN_N  = level_count(NODES, MAX_FANIN, k);
        localparam int OUT_N = level_count(NODES, MAX_FANIN, k + 1);

        logic [IN_N-1:0][ENTRY_W-1:0]  in_bus;
        logic                          in_strobe;
        logic [OUT_N-1:0][ENTRY_W-1:0] out_bus;
        logic                          out_strobe;

        if (k == 0) begin : g_first
            assign in_bus    = leaves;
            assign in_strobe = input_strobe;
        end else begin : g_next
            assign in_bus    = g_lvl[k-1].out_bus;
            assign in_strobe = g_lvl[k-1].out_strobe;
        end

        convergecast_level #(
            .DATA_WIDTH  (DATA_WIDTH),
            .INDEX_WIDTH (INDEX_WIDTH),
            .MAX_FANIN   (MAX_FANIN),
            .IN_COUNT    (IN_N)
        ) u_level (
            .clock       (clock),
            .reset_n     (reset_n),
            .in_strobe   (in_strobe),
            .in_entries  (in_bus),
            .out_strobe  (out_strobe),
            .out_entries (out_bus)
        );
    end

    entry_t root;

    assign root          = g_lvl[DEPTH-1].out_bus[0];
    assign output_strobe = g_lvl[DEPTH-1].out_strobe;
    assign output_valid  = root.valid;
    assign output_data   = root.data;
    assign output_index  = root.index;

endmodule
